// File: rtl/lift_scan_if.sv
// Request and status bundle between the request path, the lift controller and
// the motor/door drivers.
interface lift_scan_if #(
  parameter int FLOORS = 4,
  parameter int FLW    = $clog2(FLOORS)
);
  logic              req_valid;
  logic [FLW-1:0]    req_floor;
  logic [1:0]        req_type;
  logic [1:0]        dout;
  logic [FLW-1:0]    cur_floor;
  logic              door_open;
  logic [FLOORS-1:0] pending;
  logic              req_err;
  logic              busy;

  modport master (
    output req_valid, req_floor, req_type,
    input  dout, cur_floor, door_open, pending, req_err, busy
  );

  modport slave (
    input  req_valid, req_floor, req_type,
    output dout, cur_floor, door_open, pending, req_err, busy
  );
endinterface

// File: rtl/lift_scan_ctrl.sv
// SCAN (collective control) elevator controller: hall-up/hall-down/cab request
// bitmaps, timed floor travel and door dwell, UP/DOWN/STAY motor encoding.
module lift_scan_ctrl #(
  parameter int FLOORS     = 4,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3,
  parameter int FLW        = $clog2(FLOORS)
) (
  input logic        clk,
  input logic        rst,
  lift_scan_if.slave bus
);

  localparam int MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0]  TRAVEL_LOAD = CW'(TRAVEL_CYC - 1);
  localparam logic [CW-1:0]  DOOR_LOAD   = CW'(DOOR_CYC - 1);
  localparam logic [FLW-1:0] TOP         = FLW'(FLOORS - 1);
  localparam logic [FLW:0]   FLOORS_EXT  = (FLW + 1)'(FLOORS);

  localparam logic [1:0] T_UP  = 2'b00;
  localparam logic [1:0] T_DN  = 2'b01;
  localparam logic [1:0] T_CAB = 2'b10;
  localparam logic [1:0] T_BAD = 2'b11;

  localparam logic [1:0] D_UP   = 2'b00;
  localparam logic [1:0] D_DOWN = 2'b01;
  localparam logic [1:0] D_STAY = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

  function automatic logic [FLOORS-1:0] onehot(input logic [FLW-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i == int'(f));
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] above_mask(input logic [FLW-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] below_mask(input logic [FLW-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  state_t            state;
  logic              dir_up;
  logic [FLW-1:0]    cur_floor_q;
  logic [FLOORS-1:0] up_q, dn_q, cab_q;
  logic [CW-1:0]     trav_cnt, dwell_cnt;
  logic [1:0]        dout_q;
  logic              door_q, err_q;

  logic [FLOORS-1:0] pend;
  logic              req_is_up, req_is_dn, req_is_cab, req_legal;
  logic [FLOORS-1:0] req_bit, set_up, set_dn, set_cab;
  logic [FLW-1:0]    tgt;
  logic [FLOORS-1:0] tgt_bit, above, below;
  logic              arrive, svc_up, req_match, absorb;
  logic              here, any_above, any_below, stop;
  logic              entry_up, ahead_empty, dir_after, enter_door;
  logic [FLOORS-1:0] clr_up, clr_dn, clr_cab;

  assign pend = up_q | dn_q | cab_q;

  // tgt is the floor being decided on: the current floor when idle or in the
  // doorway, the floor being arrived at while moving.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves a value unassigned, which would infer a latch.
    req_is_up  = (bus.req_type == T_UP);
    req_is_dn  = (bus.req_type == T_DN);
    req_is_cab = (bus.req_type == T_CAB);
    req_legal  = bus.req_valid
              && ({1'b0, bus.req_floor} < FLOORS_EXT)
              && (bus.req_type != T_BAD)
              && !(req_is_up && bus.req_floor == TOP)
              && !(req_is_dn && bus.req_floor == '0);
    req_bit    = req_legal ? onehot(bus.req_floor) : '0;

    arrive = 1'b0;
    tgt    = cur_floor_q;
    svc_up = dir_up;
    case (state)
      MOVE_UP: begin
        arrive = (trav_cnt == '0);
        tgt    = cur_floor_q + FLW'(1);
        svc_up = 1'b1;
      end
      MOVE_DN: begin
        arrive = (trav_cnt == '0);
        tgt    = cur_floor_q - FLW'(1);
        svc_up = 1'b0;
      end
      default: ;
    endcase

    tgt_bit   = onehot(tgt);
    above     = pend & above_mask(tgt);
    below     = pend & below_mask(tgt);
    any_above = |above;
    any_below = |below;
    here      = |(pend & tgt_bit);

    req_match = req_legal && (bus.req_floor == tgt)
             && (req_is_cab || (req_is_up && svc_up) || (req_is_dn && !svc_up));

    stop = 1'b0;
    if (state == MOVE_UP)
      stop = cab_q[tgt] | up_q[tgt] | (dn_q[tgt] & ~any_above) | (tgt == TOP) | req_match;
    else if (state == MOVE_DN)
      stop = cab_q[tgt] | dn_q[tgt] | (up_q[tgt] & ~any_below) | (tgt == '0) | req_match;

    absorb     = req_match && ((state == DOOR) || (arrive && stop));
    enter_door = ((state == IDLE) && here) || (arrive && stop);

    // From IDLE, serve the opposite hall call if it is the only one here, so
    // the doorway always clears the bit that opened it.
    case (state)
      MOVE_UP: entry_up = 1'b1;
      MOVE_DN: entry_up = 1'b0;
      default: entry_up = dir_up ? !(dn_q[tgt] && !up_q[tgt])
                                 : (up_q[tgt] && !dn_q[tgt]);
    endcase
    ahead_empty = entry_up ? !any_above : !any_below;
    dir_after   = entry_up ^ ahead_empty;

    clr_up  = '0;
    clr_dn  = '0;
    clr_cab = '0;
    if (enter_door) begin
      clr_cab = tgt_bit;
      clr_up  = (entry_up || ahead_empty)  ? tgt_bit : '0;
      clr_dn  = (!entry_up || ahead_empty) ? tgt_bit : '0;
    end

    set_up  = (!absorb && req_is_up)  ? req_bit : '0;
    set_dn  = (!absorb && req_is_dn)  ? req_bit : '0;
    set_cab = (!absorb && req_is_cab) ? req_bit : '0;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dir_up      <= 1'b1;
      cur_floor_q <= '0;
      up_q        <= '0;
      dn_q        <= '0;
      cab_q       <= '0;
      trav_cnt    <= '0;
      dwell_cnt   <= '0;
      dout_q      <= D_STAY;
      door_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= bus.req_valid && !req_legal;

      // Same-edge set beats clear; absorbed requests never reach set_*.
      up_q  <= (up_q  & ~clr_up)  | set_up;
      dn_q  <= (dn_q  & ~clr_dn)  | set_dn;
      cab_q <= (cab_q & ~clr_cab) | set_cab;

      case (state)
        IDLE: begin
          if (here) begin
            state     <= DOOR;
            dir_up    <= dir_after;
            dwell_cnt <= DOOR_LOAD;
            dout_q    <= D_STAY;
            door_q    <= 1'b1;
          end else if (any_above && (dir_up || !any_below)) begin
            state    <= MOVE_UP;
            dir_up   <= 1'b1;
            trav_cnt <= TRAVEL_LOAD;
            dout_q   <= D_UP;
          end else if (any_below) begin
            state    <= MOVE_DN;
            dir_up   <= 1'b0;
            trav_cnt <= TRAVEL_LOAD;
            dout_q   <= D_DOWN;
          end
        end

        MOVE_UP, MOVE_DN: begin
          if (arrive) begin
            cur_floor_q <= tgt;
            if (stop) begin
              state     <= DOOR;
              dir_up    <= dir_after;
              dwell_cnt <= DOOR_LOAD;
              dout_q    <= D_STAY;
              door_q    <= 1'b1;
            end else begin
              trav_cnt <= TRAVEL_LOAD;
            end
          end else begin
            trav_cnt <= trav_cnt - CW'(1);
          end
        end

        DOOR: begin
          if (absorb) begin
            dwell_cnt <= DOOR_LOAD;
          end else if (dwell_cnt == '0) begin
            state  <= IDLE;
            dout_q <= D_STAY;
            door_q <= 1'b0;
          end else begin
            dwell_cnt <= dwell_cnt - CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout      = dout_q;
  assign bus.cur_floor = cur_floor_q;
  assign bus.door_open = door_q;
  assign bus.pending   = pend;
  assign bus.req_err   = err_q;
  assign bus.busy      = (state != IDLE) || (|pend);

endmodule
